athena_bridge_initiator: RTL and testbench
==========================================

# athena_bridge_initiator

Initiator-side driver for the `bus_if` bridge, used to talk to the core's memory-mapped register targets such as the DIP-switch block at 0x0020_0000. It accepts single read or write commands on a valid/ready port and runs one bridge transaction per command. Every command produces exactly one response on a valid/ready port, which is either data or a timeout error. It sits between a core-side sequencer (boot defaults, test harness) and the register targets.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16: maximum wait for `rd_data_valid` after a read strobe. Legal range 1..255.

Ports:
- `clk`  in  1: sole clock, same net as `bridge.clk`.
- `reset_n`  in  1: synchronous, active-low reset.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: command accepted when high together with `cmd_valid`.
- `cmd_wr`  in  1: 1 = write, 0 = read.
- `cmd_addr`  in  32: target address.
- `cmd_wr_data`  in  32: write data.
- `rsp_valid`  out  1: response present; held until accepted.
- `rsp_ready`  in  1: response consumed.
- `rsp_data`  out  32: read data, or 0 for a clean write.
- `rsp_error`  out  1: timeout or readback mismatch.
- `bridge`  `bus_if`, initiator side:
  - drives `addr`, `wr`, `wr_data`, `rd`;
  - samples `rd_data`, `rd_data_valid`.

## Operation
- FSM states: IDLE, WRITE, READ_ISSUE, READ_WAIT, RESP.
- IDLE:
  - `cmd_ready` = 1.
  - On handshake, latch addr, wr flag and data. Go to WRITE if `cmd_wr`, else READ_ISSUE.
  - `cmd_ready` is 0 in every other state. Only one transaction is ever outstanding.
- WRITE:
  - `bridge.addr` = latched addr, `bridge.wr_data` = latched data, `bridge.wr` = 1 for exactly one cycle.
  - Then RESP with `rsp_data` = 0 and `rsp_error` = 0 (see Configuration).
- READ_ISSUE:
  - `bridge.rd` = 1 for exactly one cycle with addr driven.
  - Then READ_WAIT, timeout counter cleared to 0.
- READ_WAIT:
  - `bridge.addr` stays stable because targets decode addr on every cycle.
  - If `rd_data_valid` = 1: capture `rd_data` into `rsp_data`, set `rsp_error` = 0, go to RESP.
  - Otherwise increment the counter. When it reaches `TIMEOUT_CYCLES`: `rsp_data` = 32'hFFFF_FFFF, `rsp_error` = 1, go to RESP.
  - If valid arrives in the same cycle the counter reaches its limit, valid wins.
- RESP:
  - `rsp_valid` = 1, with `rsp_data` and `rsp_error` stable.
  - On `rsp_ready`, go to IDLE.
- `rd_data_valid` is ignored in every state except READ_WAIT. A stray pulse never produces a response.
- `bridge.addr` and `bridge.wr_data` keep their last value after a transaction. `bridge.rd` and `bridge.wr` are 0 outside their single strobe cycle.
- Counter width is $clog2(`TIMEOUT_CYCLES`+1).

## Timing
- Reset (`reset_n` = 0 at a clk edge):
  - FSM returns to IDLE from any state. Any pending command or response is discarded.
  - `cmd_ready`, `rsp_valid`, `rsp_error`, `bridge.rd` and `bridge.wr` are 0.
  - `rsp_data`, `bridge.addr` and `bridge.wr_data` are 0.
  - `cmd_ready` rises in the first cycle after reset deasserts.
- Write accepted at cycle T: `bridge.wr` high in T+1; `rsp_valid` high from T+2.
- Read accepted at T with a registered target: `bridge.rd` high in T+1; `rd_data_valid` seen in T+2; `rsp_valid` high from T+3.
- Timeout read: `rsp_valid` high from T+2+`TIMEOUT_CYCLES`.
- Back-to-back throughput:
  - `rsp_ready` tied high: the next command is accepted the cycle after the response handshake. Minimum 3 cycles per write, 4 per read.
  - `rsp_ready` low: `rsp_valid` and all response fields stay stable indefinitely.

## Configuration
- Macro: `ATHENA_BRIDGE_INIT_READBACK_EN`.
- Defined:
  - After the WRITE strobe the FSM passes through READ_ISSUE/READ_WAIT on the same address.
  - Readback equal to the written data: `rsp_data` = readback, `rsp_error` = 0.
  - Readback different: `rsp_data` = readback, `rsp_error` = 1.
  - Readback times out: 32'hFFFF_FFFF with `rsp_error` = 1.
  - Write response is delayed to T+4 (no timeout).
- Undefined: write responds at T+2 with data 0 and no readback.

## Structure
- Shared `athena` package:
  - `bridge_init_state_e` (FSM enum);
  - `BRIDGE_TIMEOUT_DEFAULT` = 16;
  - `BRIDGE_ERR_DATA` = 32'hFFFF_FFFF.
- One sub-module, `athena_timeout_counter`, with clear / enable / expired and parameterised limit.
- FSM, command latch and bridge drive live in the top module.

## Test plan
- Write 0x0020_0004 data 2 to the DIP target:
  - `bridge.wr` high exactly 1 cycle at T+1;
  - `rsp_valid` at T+2 with data 0, error 0;
  - readback of 0x0020_0004 returns 2 at T+3 of that read.
- Read an unmapped address 0x0020_0040: response data 0, error 0, latency 3.
- Target stub that never asserts `rd_data_valid`, `TIMEOUT_CYCLES` = 4: `rsp_valid` at T+6 with 32'hFFFF_FFFF, error 1.
- `rsp_ready` held low 10 cycles after a read of 0x0020_0008:
  - `rsp_valid` and `rsp_data` stable throughout;
  - `cmd_ready` stays 0;
  - a queued `cmd_valid` is accepted only after the handshake.
- `reset_n` pulled low during READ_WAIT: `bridge.rd` 0, `rsp_valid` 0; a late `rd_data_valid` produces no response; next command works normally.
- With `ATHENA_BRIDGE_INIT_READBACK_EN`:
  - write 3 to 0x0020_0000 on a target that masks to 1 bit → rsp data 1, error 1;
  - write 1 → error 0.

Source files
------------

// File: rtl/athena_pkg.sv
// Shared types and constants for the athena bridge initiator.
// Optional readback-after-write: ATHENA_BRIDGE_INIT_READBACK_EN.
package athena;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ_ISSUE,
    READ_WAIT,
    RESP
  } bridge_init_state_e;

  localparam int BRIDGE_TIMEOUT_DEFAULT = 16;
  localparam logic [31:0] BRIDGE_ERR_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/bus_if.sv
// Register-bridge bus between a single initiator and its targets.
// Targets decode addr every cycle and answer rd with rd_data_valid.
interface bus_if (
  input logic clk
);
  logic [31:0] addr;
  logic        wr;
  logic [31:0] wr_data;
  logic        rd;
  logic [31:0] rd_data;
  logic        rd_data_valid;

  modport initiator (
    output addr, wr, wr_data, rd,
    input  rd_data, rd_data_valid
  );

  modport target (
    input  clk, addr, wr, wr_data, rd,
    output rd_data, rd_data_valid
  );
endinterface

// File: rtl/athena_timeout_counter.sv
// Read-wait timeout counter; expired fires on the LIMIT-th enabled
// cycle after clear, so the caller can leave that same cycle.
module athena_timeout_counter
  import athena::*;
#(
  parameter int LIMIT = BRIDGE_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // next count: clear wins over enable
  always_comb begin
    count_d = count_q;
    if (clear_i)
      count_d = '0;
    else if (enable_i)
      count_d = count_q + 1'b1;
  end

  assign expired_o = enable_i && (count_q == LAST);

  // count register
  always_ff @(posedge clk) begin
    if (!reset_n)
      count_q <= '0;
    else
      count_q <= count_d;
  end
endmodule

// File: rtl/athena_bridge_initiator.sv
// Single-outstanding command-to-bridge initiator with timeout.
// Optional readback-after-write: ATHENA_BRIDGE_INIT_READBACK_EN.
module athena_bridge_initiator
  import athena::*;
#(
  parameter int TIMEOUT_CYCLES = BRIDGE_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wr_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_error,
  bus_if.initiator    bridge
);
  bridge_init_state_e state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        cnt_clear;
  logic        cnt_en;
  logic        cnt_expired;
`ifdef ATHENA_BRIDGE_INIT_READBACK_EN
  logic        wr_q, wr_d;
`endif

  athena_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear_i   (cnt_clear),
    .enable_i  (cnt_en),
    .expired_o (cnt_expired)
  );

  assign bridge.addr    = addr_q;
  assign bridge.wr_data = wdata_q;
  assign rsp_data       = rdata_q;
  assign rsp_error      = err_q;

  // next state, strobes and handshakes
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
`ifdef ATHENA_BRIDGE_INIT_READBACK_EN
    wr_d       = wr_q;
`endif
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    bridge.wr  = 1'b0;
    bridge.rd  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = reset_n;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wr_data;
`ifdef ATHENA_BRIDGE_INIT_READBACK_EN
          wr_d    = cmd_wr;
`endif
          state_d = cmd_wr ? WRITE : READ_ISSUE;
        end
      end
      WRITE: begin
        bridge.wr = 1'b1;
`ifdef ATHENA_BRIDGE_INIT_READBACK_EN
        state_d   = READ_ISSUE;
`else
        rdata_d   = '0;
        err_d     = 1'b0;
        state_d   = RESP;
`endif
      end
      READ_ISSUE: begin
        bridge.rd = 1'b1;
        cnt_clear = 1'b1;
        state_d   = READ_WAIT;
      end
      READ_WAIT: begin
        cnt_en = 1'b1;
        if (bridge.rd_data_valid) begin
          rdata_d = bridge.rd_data;
`ifdef ATHENA_BRIDGE_INIT_READBACK_EN
          err_d   = wr_q && (bridge.rd_data != wdata_q);
`else
          err_d   = 1'b0;
`endif
          state_d = RESP;
        end else if (cnt_expired) begin
          rdata_d = BRIDGE_ERR_DATA;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state, command latch and response registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef ATHENA_BRIDGE_INIT_READBACK_EN
      wr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef ATHENA_BRIDGE_INIT_READBACK_EN
      wr_q    <= wr_d;
`endif
    end
  end
endmodule

// File: tb/tb_athena_bridge_initiator.sv
// Bench for athena_bridge_initiator: register-target stub plus a
// transaction-timing model checked every cycle.
module tb_athena_bridge_initiator;
  import athena::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_wr = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wr_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_error;

  always #5 clk = ~clk;

  bus_if bif (.clk(clk));

  athena_bridge_initiator #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_wr      (cmd_wr),
    .cmd_addr    (cmd_addr),
    .cmd_wr_data (cmd_wr_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_error   (rsp_error),
    .bridge      (bif)
  );

  function automatic bit mapped(input logic [31:0] a);
    return a == 32'h0020_0000 || a == 32'h0020_0004 ||
           a == 32'h0020_0008;
  endfunction

  function automatic int idx(input logic [31:0] a);
    return int'(a[3:2]);
  endfunction

  function automatic logic [31:0] store_val(input int i,
                                            input logic [31:0] d);
    return (i == 0) ? {31'b0, d[0]} : d;
  endfunction

  // registered target stub: DIP register at 0 is 1 bit wide
  logic        mute = 1'b0;
  logic        stray = 1'b0;
  logic        tb_clr = 1'b1;
  logic [31:0] mem [0:2];
  logic        sv_q = 1'b0;
  logic [31:0] sd_q = '0;

  always @(posedge clk) begin
    if (tb_clr) begin
      mem[0] <= '0;
      mem[1] <= '0;
      mem[2] <= '0;
    end else if (bif.wr && mapped(bif.addr)) begin
      mem[idx(bif.addr)] <= store_val(idx(bif.addr), bif.wr_data);
    end
    sv_q <= bif.rd && !mute;
    sd_q <= mapped(bif.addr) ? mem[idx(bif.addr)] : 32'h0;
  end

  assign bif.rd_data       = sd_q;
  assign bif.rd_data_valid = sv_q | stray;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit started = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  // transaction model: when each command responds and with what
  bit          m_idle = 1;
  bit          m_wr = 0;
  int          m_T = 0;
  int          m_start = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wd = '0;
  logic [31:0] m_data = '0;
  bit          m_err = 0;
  logic [31:0] m_mem [0:2] = '{default: '0};
  logic [31:0] m_rb;

  initial forever begin
    @(posedge clk);
    if (!reset_n) begin
      m_idle = 1;
      m_addr = '0;
      m_wd   = '0;
    end else if (m_idle) begin
      if (cmd_valid) begin
        m_idle = 0;
        m_T    = cyc;
        m_wr   = cmd_wr;
        m_addr = cmd_addr;
        m_wd   = cmd_wr_data;
        if (cmd_wr) begin
          if (mapped(cmd_addr))
            m_mem[idx(cmd_addr)] =
              store_val(idx(cmd_addr), cmd_wr_data);
`ifdef ATHENA_BRIDGE_INIT_READBACK_EN
          m_rb = mapped(cmd_addr) ? m_mem[idx(cmd_addr)] : 32'h0;
          if (mute) begin
            m_start = cyc + 3 + TO;
            m_data  = 32'hFFFF_FFFF;
            m_err   = 1;
          end else begin
            m_start = cyc + 4;
            m_data  = m_rb;
            m_err   = (m_rb != cmd_wr_data);
          end
`else
          m_start = cyc + 2;
          m_data  = 32'h0;
          m_err   = 0;
`endif
        end else if (mute) begin
          m_start = cyc + 2 + TO;
          m_data  = 32'hFFFF_FFFF;
          m_err   = 1;
        end else begin
          m_start = cyc + 3;
          m_data  = mapped(cmd_addr) ? m_mem[idx(cmd_addr)] : 32'h0;
          m_err   = 0;
        end
      end
    end else if (cyc >= m_start && rsp_ready) begin
      m_idle = 1;
    end
    started = 1;
    cyc <= cyc + 1;
  end

  // per-cycle comparison against the model
  bit exp_rv;
  bit exp_rd;
  bit rv_prev = 0;
  int rv_rise = -1;

  initial forever begin
    @(negedge clk);
    if (started) begin
      exp_rv = !m_idle && cyc >= m_start;
      exp_rd = !m_idle && !m_wr && cyc == m_T + 1;
`ifdef ATHENA_BRIDGE_INIT_READBACK_EN
      if (!m_idle && m_wr && cyc == m_T + 2)
        exp_rd = 1;
`endif
      chk("cmd_ready", 32'(cmd_ready), 32'(m_idle && reset_n));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      chk("bridge_wr", 32'(bif.wr),
          32'(!m_idle && m_wr && cyc == m_T + 1));
      chk("bridge_rd", 32'(bif.rd), 32'(exp_rd));
      chk("bridge_addr", bif.addr, m_addr);
      chk("bridge_wr_data", bif.wr_data, m_wd);
      if (exp_rv) begin
        chk("rsp_data", rsp_data, m_data);
        chk("rsp_error", 32'(rsp_error), 32'(m_err));
      end
    end
    if (rsp_valid && !rv_prev)
      rv_rise = cyc;
    rv_prev = rsp_valid;
  end

  task automatic send(input logic w, input logic [31:0] a,
                      input logic [31:0] d, output int t);
    cmd_wr      = w;
    cmd_addr    = a;
    cmd_wr_data = d;
    cmd_valid   = 1'b1;
    t = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_wait: got no cmd_ready expected accept");
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [31:0] d, output logic e,
                          output int hs);
    hs = -1;
    d  = '0;
    e  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        d  = rsp_data;
        e  = rsp_error;
        hs = cyc;
        break;
      end
    end
    if (hs < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rsp_wait: got no response expected handshake");
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1);
  end

  int          t, t2, hs, hs_c;
  logic [31:0] d;
  logic        e;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_error", 32'(rsp_error), 32'h0);
    chk("rst_addr", bif.addr, 32'h0);
    chk("rst_wr_data", bif.wr_data, 32'h0);
    chk("rst_wr", 32'(bif.wr), 32'h0);
    chk("rst_rd", 32'(bif.rd), 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    tb_clr = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(cmd_ready), 32'h1);

    // write DIP register 1 then read it back
    send(1'b1, 32'h0020_0004, 32'd2, t);
    wait_rsp(d, e, hs);
`ifdef ATHENA_BRIDGE_INIT_READBACK_EN
    chk("wr_latency", 32'(rv_rise - t), 32'd4);
    chk("wr_data", d, 32'd2);
`else
    chk("wr_latency", 32'(rv_rise - t), 32'd2);
    chk("wr_data", d, 32'd0);
`endif
    chk("wr_err", 32'(e), 32'h0);
    send(1'b0, 32'h0020_0004, 32'h0, t);
    wait_rsp(d, e, hs);
    chk("rd_latency", 32'(rv_rise - t), 32'd3);
    chk("rd_data", d, 32'd2);

    // unmapped read answers 0
    send(1'b0, 32'h0020_0040, 32'h0, t);
    wait_rsp(d, e, hs);
    chk("unmap_latency", 32'(rv_rise - t), 32'd3);
    chk("unmap_data", d, 32'd0);
    chk("unmap_err", 32'(e), 32'h0);

    // response held with rsp_ready low, queued command waits
    send(1'b1, 32'h0020_0008, 32'hA5A5_0001, t);
    wait_rsp(d, e, hs);
    rsp_ready = 1'b0;
    send(1'b0, 32'h0020_0008, 32'h0, t);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    chk("hold_data", rsp_data, 32'hA5A5_0001);
    cmd_wr      = 1'b1;
    cmd_addr    = 32'h0020_0000;
    cmd_wr_data = 32'd1;
    cmd_valid   = 1'b1;
    repeat (10) @(posedge clk);
    #1 rsp_ready = 1'b1;
    hs_c = cyc;
    send(1'b1, 32'h0020_0000, 32'd1, t2);
    chk("queued_accept", 32'(t2), 32'(hs_c + 1));
    wait_rsp(d, e, hs);

    // silent target: timeout response
    mute = 1'b1;
    send(1'b0, 32'h0020_0004, 32'h0, t);
    wait_rsp(d, e, hs);
    mute = 1'b0;
    chk("to_latency", 32'(rv_rise - t), 32'(2 + TO));
    chk("to_data", d, 32'hFFFF_FFFF);
    chk("to_err", 32'(e), 32'h1);

    // stray valid while idle
    stray = 1'b1;
    @(posedge clk);
    #1 stray = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stray_idle", 32'(rsp_valid), 32'h0);
    end

    // reset during READ_WAIT, then a late valid
    mute = 1'b1;
    send(1'b0, 32'h0020_0004, 32'h0, t);
    @(posedge clk);
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mid_rd", 32'(bif.rd), 32'h0);
    chk("rst_mid_rv", 32'(rsp_valid), 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    mute  = 1'b0;
    stray = 1'b1;
    @(posedge clk);
    #1 stray = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("late_valid", 32'(rsp_valid), 32'h0);
    end
    send(1'b0, 32'h0020_0004, 32'h0, t);
    wait_rsp(d, e, hs);
    chk("post_rst_lat", 32'(rv_rise - t), 32'd3);
    chk("post_rst_data", d, 32'd2);

    // back-to-back throughput with rsp_ready high
    send(1'b1, 32'h0020_0008, 32'h0000_1234, t);
    send(1'b1, 32'h0020_0008, 32'h0000_5678, t2);
`ifdef ATHENA_BRIDGE_INIT_READBACK_EN
    chk("b2b_wr", 32'(t2 - t), 32'd5);
`else
    chk("b2b_wr", 32'(t2 - t), 32'd3);
`endif
    send(1'b0, 32'h0020_0008, 32'h0, t);
    chk("b2b_wr_rd", 32'(t - t2) >= 32'd3 ? 32'd1 : 32'd0, 32'd1);
    send(1'b0, 32'h0020_0004, 32'h0, t2);
    chk("b2b_rd", 32'(t2 - t), 32'd4);
    wait_rsp(d, e, hs);
    chk("b2b_rd_data", d, 32'd2);

`ifdef ATHENA_BRIDGE_INIT_READBACK_EN
    // readback through the 1-bit DIP register
    send(1'b1, 32'h0020_0000, 32'd3, t);
    wait_rsp(d, e, hs);
    chk("rb3_data", d, 32'd1);
    chk("rb3_err", 32'(e), 32'h1);
    send(1'b1, 32'h0020_0000, 32'd1, t);
    wait_rsp(d, e, hs);
    chk("rb1_data", d, 32'd1);
    chk("rb1_err", 32'(e), 32'h0);
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
